// File: rtl/fir_coeff_ctrl.sv
// Shadow/active coefficient banks for one FIR filter, with a
// stall-swap-flush sequence so no output mixes two coefficient sets.
module fir_coeff_ctrl #(
    parameter int DATA_WIDTH = 24,
    parameter int FIR_DEPTH  = 16,
    parameter int ADDR_WIDTH = $clog2(FIR_DEPTH)
) (
    input  logic                            i_clk,
    input  logic                            i_rst,
    input  logic                            i_wr_en,
    input  logic [ADDR_WIDTH-1:0]           iv_wr_addr,
    input  logic [DATA_WIDTH-1:0]           iv_wr_data,
    input  logic                            i_commit,
    output logic                            o_busy,
    input  logic [DATA_WIDTH-1:0]           iv_din,
    input  logic                            i_din_valid,
    output logic                            o_din_ready,
    output logic [DATA_WIDTH-1:0]           ov_fir_din,
    output logic                            o_fir_din_valid,
    output logic [FIR_DEPTH*DATA_WIDTH-1:0] ov_weights,
    input  logic                            i_fir_dout_valid,
    output logic                            o_dout_valid
);

    localparam int CNT_W = $clog2(FIR_DEPTH + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWAP  = 2'd1,
        FLUSH = 2'd2
    } state_t;

    state_t                          state;
    state_t                          state_d;
    logic                            pending;
    logic [CNT_W-1:0]                cnt;
    logic                            m1;
    logic                            m2;
    logic [FIR_DEPTH*DATA_WIDTH-1:0] shadow;

    always_comb begin
        state_d = state;
        unique case (state)
            IDLE:    if (i_commit || pending) state_d = SWAP;
            SWAP:    state_d = FLUSH;
            FLUSH:   if (cnt == '0) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign o_din_ready  = (state == IDLE);
    assign o_busy       = (state != IDLE) || pending;
    assign o_dout_valid = i_fir_dout_valid & ~m2;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state   <= IDLE;
            pending <= 1'b0;
            cnt     <= '0;
        end else begin
            state <= state_d;
            if (state == IDLE && state_d == SWAP)
                pending <= 1'b0;
            else if (i_commit && state != IDLE)
                pending <= 1'b1;
            if (state == SWAP)
                cnt <= CNT_W'(FIR_DEPTH - 1);
            else if (state == FLUSH && cnt != '0)
                cnt <= cnt - 1'b1;
        end
    end

    // Shadow takes writes in any state; active copies it only on SWAP exit,
    // so a write landing on that same edge stays in the shadow bank.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            shadow     <= '0;
            ov_weights <= '0;
        end else begin
            for (int k = 0; k < FIR_DEPTH; k++) begin
                if (i_wr_en && int'(iv_wr_addr) == k)
                    shadow[k*DATA_WIDTH +: DATA_WIDTH] <= iv_wr_data;
            end
            if (state == SWAP)
                ov_weights <= shadow;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            ov_fir_din      <= '0;
            o_fir_din_valid <= 1'b0;
            m1              <= 1'b0;
            m2              <= 1'b0;
        end else begin
            m1 <= (state == FLUSH);
            m2 <= m1;
            unique case (state)
                IDLE: begin
                    ov_fir_din      <= iv_din;
                    o_fir_din_valid <= i_din_valid & o_din_ready;
                end
                FLUSH: begin
                    ov_fir_din      <= '0;
                    o_fir_din_valid <= 1'b1;
                end
                default: begin
                    ov_fir_din      <= '0;
                    o_fir_din_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fir_coeff_ctrl.sv
// Directed checks of bank writes, commit/flush sequencing,
// output gating and reset abort for fir_coeff_ctrl.
module tb_fir_coeff_ctrl;

    localparam int DW = 24;
    localparam int FD = 16;
    localparam int AW = 5;

    logic              i_clk = 1'b0;
    logic              i_rst = 1'b1;
    logic              i_wr_en = 1'b0;
    logic [AW-1:0]     iv_wr_addr = '0;
    logic [DW-1:0]     iv_wr_data = '0;
    logic              i_commit = 1'b0;
    logic              o_busy;
    logic [DW-1:0]     iv_din = '0;
    logic              i_din_valid = 1'b0;
    logic              o_din_ready;
    logic [DW-1:0]     ov_fir_din;
    logic              o_fir_din_valid;
    logic [FD*DW-1:0]  ov_weights;
    logic              i_fir_dout_valid = 1'b0;
    logic              o_dout_valid;

    int total = 0;
    int bad   = 0;

    fir_coeff_ctrl #(
        .DATA_WIDTH(DW),
        .FIR_DEPTH (FD),
        .ADDR_WIDTH(AW)
    ) dut (
        .i_clk           (i_clk),
        .i_rst           (i_rst),
        .i_wr_en         (i_wr_en),
        .iv_wr_addr      (iv_wr_addr),
        .iv_wr_data      (iv_wr_data),
        .i_commit        (i_commit),
        .o_busy          (o_busy),
        .iv_din          (iv_din),
        .i_din_valid     (i_din_valid),
        .o_din_ready     (o_din_ready),
        .ov_fir_din      (ov_fir_din),
        .o_fir_din_valid (o_fir_din_valid),
        .ov_weights      (ov_weights),
        .i_fir_dout_valid(i_fir_dout_valid),
        .o_dout_valid    (o_dout_valid)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic wr(input int addr, input logic [DW-1:0] data);
        i_wr_en    = 1'b1;
        iv_wr_addr = AW'(addr);
        iv_wr_data = data;
        tick();
        i_wr_en = 1'b0;
    endtask

    function automatic logic [31:0] tap(input int k);
        return 32'(ov_weights[k*DW +: DW]);
    endfunction

    task automatic wait_idle();
        int n;
        n = 0;
        while ((o_busy || !o_din_ready) && n < 100) begin
            tick();
            n++;
        end
        chk("idle_timeout", 32'(n < 100), 32'd1);
    endtask

    task automatic commit_now();
        i_commit = 1'b1;
        tick();
        i_commit = 1'b0;
    endtask

    initial begin
        int stall;
        int supp;
        logic [31:0] e;

        repeat (2) tick();
        i_rst = 1'b0;
        #1;
        chk("rst_ready", 32'(o_din_ready), 32'd1);
        chk("rst_busy", 32'(o_busy), 32'd0);
        chk("rst_fvalid", 32'(o_fir_din_valid), 32'd0);
        chk("rst_fdin", 32'(ov_fir_din), 32'd0);
        chk("rst_w", 32'(ov_weights == '0), 32'd1);

        // plain forwarding
        iv_din      = 24'd123;
        i_din_valid = 1'b1;
        tick();
        chk("fwd_data", 32'(ov_fir_din), 32'd123);
        chk("fwd_valid", 32'(o_fir_din_valid), 32'd1);
        i_din_valid = 1'b0;
        tick();
        chk("fwd_novalid", 32'(o_fir_din_valid), 32'd0);

        for (int k = 0; k < FD; k++) wr(k, DW'(k + 1));
        chk("wr_no_active", 32'(ov_weights == '0), 32'd1);

        // commit with an accepted impulse in the same cycle
        i_fir_dout_valid = 1'b1;
        i_commit    = 1'b1;
        iv_din      = 24'd1000;
        i_din_valid = 1'b1;
        tick();
        i_commit    = 1'b0;
        i_din_valid = 1'b0;
        stall = 0;
        supp  = 0;
        for (int c = 1; c <= 20; c++) begin
            #1;
            chk($sformatf("c%0d_ready", c), 32'(o_din_ready),
                32'(!(c >= 1 && c <= 17)));
            chk($sformatf("c%0d_busy", c), 32'(o_busy),
                32'(c >= 1 && c <= 17));
            chk($sformatf("c%0d_fvalid", c), 32'(o_fir_din_valid),
                32'(c == 1 || (c >= 3 && c <= 18)));
            chk($sformatf("c%0d_dvalid", c), 32'(o_dout_valid),
                32'(!(c >= 4 && c <= 19)));
            if (c == 1) begin
                chk("imp_data", 32'(ov_fir_din), 32'd1000);
                chk("imp_oldw", tap(0), 32'd0);
            end
            if (c >= 3 && c <= 18)
                chk($sformatf("c%0d_zero", c), 32'(ov_fir_din), 32'd0);
            if (c == 2)
                for (int k = 0; k < FD; k++)
                    chk($sformatf("neww%0d", k), tap(k), 32'(k + 1));
            if (!o_din_ready) stall++;
            if (!o_dout_valid) supp++;
            tick();
        end
        chk("stall17", 32'(stall), 32'd17);
        chk("supp16", 32'(supp), 32'd16);
        i_fir_dout_valid = 1'b0;

        // out-of-range address is dropped
        wr(20, 24'd555);
        commit_now();
        wait_idle();
        for (int k = 0; k < FD; k++)
            chk($sformatf("oor_w%0d", k), tap(k), 32'(k + 1));

        // commits during SWAP/FLUSH fold into one extra sequence
        i_commit = 1'b1;
        tick();
        i_commit = 1'b0;
        stall = 0;
        for (int c = 1; c <= 40; c++) begin
            i_commit = (c == 5 || c == 8);
            #1;
            e = 32'(!((c >= 1 && c <= 17) || (c >= 19 && c <= 35)));
            chk($sformatf("p%0d_ready", c), 32'(o_din_ready), e);
            chk($sformatf("p%0d_busy", c), 32'(o_busy),
                32'(c >= 1 && c <= 35));
            if (!o_din_ready) stall++;
            tick();
            i_commit = 1'b0;
        end
        chk("stall34", 32'(stall), 32'd34);

        // write landing on the SWAP->FLUSH edge
        commit_now();
        chk("sw_busy", 32'(o_busy), 32'd1);
        wr(3, 24'h7FFFFF);
        chk("sw_tap3_old", tap(3), 32'd4);
        wait_idle();
        chk("sw_tap3_keep", tap(3), 32'd4);
        commit_now();
        wait_idle();
        chk("sw_tap3_new", tap(3), 32'h7FFFFF);
        chk("sw_tap2", tap(2), 32'd3);

        // reset in FLUSH cycle 5
        i_fir_dout_valid = 1'b1;
        commit_now();
        repeat (5) tick();
        chk("ab_pre_mask", 32'(o_dout_valid), 32'd0);
        i_rst = 1'b1;
        #1;
        chk("ab_w", 32'(ov_weights == '0), 32'd1);
        chk("ab_busy", 32'(o_busy), 32'd0);
        chk("ab_ready", 32'(o_din_ready), 32'd1);
        chk("ab_fvalid", 32'(o_fir_din_valid), 32'd0);
        chk("ab_dvalid", 32'(o_dout_valid), 32'd1);
        #2;
        i_rst = 1'b0;
        tick();
        chk("ab_ready2", 32'(o_din_ready), 32'd1);
        chk("ab_busy2", 32'(o_busy), 32'd0);
        chk("ab_dvalid2", 32'(o_dout_valid), 32'd1);
        chk("ab_w2", 32'(ov_weights == '0), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fir_coeff_ctrl.md
# fir_coeff_ctrl

Coefficient-configuration and sequencing controller that sits in front of one `fir_filter` instance. It holds a host-writable shadow coefficient bank and an active bank that drives the filter weights. On a commit it stalls the input stream, swaps banks atomically and flushes the filter pipeline with zero samples. It suppresses the filter output valid for the flush results, so downstream logic never sees a sample that mixes old and new coefficients.

## Interface
**Parameters**
- `DATA_WIDTH`, 24: sample and coefficient width, signed.
- `FIR_DEPTH`, 16: number of taps; also the number of flush samples.
- `ADDR_WIDTH`, `$clog2(FIR_DEPTH)`: coefficient address width.

**Ports**
- `i_clk`  in  1  clock; all logic on the rising edge.
- `i_rst`  in  1  reset, asynchronous, active-high.
- `i_wr_en`  in  1  coefficient write strobe to the shadow bank.
- `iv_wr_addr`  in  ADDR_WIDTH  tap index for the write.
- `iv_wr_data`  in  DATA_WIDTH  signed coefficient.
- `i_commit`  in  1  one-cycle request to swap the shadow bank into the active bank.
- `o_busy`  out  1  high whenever state ≠ IDLE or a commit is pending.
- `iv_din`  in  DATA_WIDTH  upstream sample.
- `i_din_valid`  in  1  upstream valid.
- `o_din_ready`  out  1  high only in IDLE; a sample transfers on valid & ready.
- `ov_fir_din`  out  DATA_WIDTH  registered sample to the filter.
- `o_fir_din_valid`  out  1  registered valid to the filter.
- `ov_weights`  out  FIR_DEPTH*DATA_WIDTH  active bank, flat; tap k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
- `i_fir_dout_valid`  in  1  the filter's output valid.
- `o_dout_valid`  out  1  gated output valid for downstream.

## Operation
- **Bank writes**
  - A write goes to the shadow bank whenever `i_wr_en` is high, in any state.
  - A write with `iv_wr_addr` ≥ FIR_DEPTH is ignored.
  - Writes never change the active bank directly.
- **FSM states:** IDLE, SWAP, FLUSH.
  - **IDLE → SWAP:** on `i_commit`, or when a pending commit is set.
  - **SWAP → FLUSH:** after exactly 1 cycle. At the SWAP→FLUSH edge, active ← shadow, all taps in the same edge. Load the flush counter with FIR_DEPTH−1.
  - **FLUSH:** issue one zero sample per cycle (`ov_fir_din`=0, `o_fir_din_valid`=1) for FIR_DEPTH cycles. When the counter reaches 0, go to IDLE.
- **Pending commit:** a commit arriving in SWAP or FLUSH sets a 1-deep pending flag. It is cleared when the FSM re-enters SWAP. Further commits while the flag is set are absorbed.
- **Same-cycle write and commit:** a write in the same cycle as the SWAP→FLUSH edge is not included in the swap. It lands in the shadow bank only.
- **Forwarding in IDLE:** `ov_fir_din` ← `iv_din` and `o_fir_din_valid` ← (`i_din_valid` & `o_din_ready`), both registered.
- **Forwarding in SWAP:** `o_fir_din_valid` ← 0.
- **Output mask:**
  - m1 is registered (state==FLUSH), aligned with `o_fir_din_valid`.
  - m2 is m1 delayed one cycle, aligned with the filter's registered output valid.
  - `o_dout_valid` = `i_fir_dout_valid` & ~m2.
- **Reset:**
  - Both banks reset to 0. `ov_weights`=0.
  - state=IDLE, pending=0, m1=m2=0.
  - `ov_fir_din`=0, `o_fir_din_valid`=0.
  - `o_din_ready`=1 and `o_busy`=0 immediately after release.
- **Reset mid-operation:** asserting reset mid-SWAP or mid-FLUSH aborts immediately. The active bank returns to 0 and no partial swap survives.

## Timing
- **Write-to-shadow latency:** 1 cycle.
- **Input latency:** 1 cycle from `iv_din` to `ov_fir_din`.
- **Commit sequence**, with `i_commit` high in cycle t while IDLE:
  - t+1: SWAP; `o_din_ready`=0, `o_busy`=1.
  - t+2 … t+1+FIR_DEPTH: FLUSH; new `ov_weights` visible from t+2.
  - t+2+FIR_DEPTH: IDLE; `o_din_ready`=1.
- **Zero samples:** `o_fir_din_valid`=1 with zero data during t+3 … t+2+FIR_DEPTH (FIR_DEPTH samples).
- **Suppressed outputs:** `o_dout_valid` is suppressed for exactly the FIR_DEPTH filter outputs caused by flush samples.
- **Sample accepted with the commit:** a sample accepted in cycle t (commit cycle) is forwarded at t+1. It is processed with the old weights, and its output is not suppressed.
- **Handshake:** `o_din_ready` is a function of registered state only; no combinational path from `i_din_valid`.
- **Throughput:** 1 sample/cycle in IDLE. Commit overhead is FIR_DEPTH+1 stalled cycles.

## Test plan
- **Reset:** assert reset mid-stream → all outputs at reset values; `ov_weights`=0; `o_din_ready`=1 the cycle after release.
- **Write and commit:** write taps 0..15 = k+1, then commit, then impulse 1000 → `ov_weights` changes only at t+2. After 17 stall cycles, outputs read 1000·(k+1) in tap order. No valid is seen during the flush.
- **Out-of-range write:** write addr 20 (FIR_DEPTH=16) → shadow unchanged; after commit, `ov_weights` equals the prior shadow.
- **Commits during flush:** commit at t, then again at t+5 and t+8 → exactly two full SWAP/FLUSH sequences; `o_busy` stays high continuously across them; total stall is 2·17 cycles.
- **Write at the swap edge:** write tap 3 = 0x7FFFFF during SWAP → active tap 3 keeps the old value. A second commit loads 0x7FFFFF.
- **Abort flush:** assert reset during FLUSH cycle 5 → state IDLE, weights 0, m2=0, so the next `i_fir_dout_valid` passes ungated.
